// File: rtl/edge_pkg.sv
// edge_pkg: shared types and constants for the 3x3 window reader and its edge-stage consumers
package edge_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, EMIT} state_e;
  typedef logic [23:0] pixel_t;
  localparam int WINDOW_PIXELS = 9;
  localparam int ROW_W = 2;
  localparam int TL = 0, TC = 1, TR = 2, ML = 3, MC = 4, MR = 5, BL = 6, BC = 7, BR = 8;
  function automatic logic [ROW_W-1:0] row_wrap(input logic [ROW_W-1:0] r, input logic [ROW_W-1:0] n);
    logic [ROW_W:0] s;
    s = {1'b0, r} + {1'b0, n};
    return (s >= 3'd3) ? ROW_W'(s - 3'd3) : ROW_W'(s);
  endfunction
endpackage

// File: rtl/frame_window_reader.sv
// frame_window_reader: reads a line's 3x3 neighbourhoods from a 3-row circular buffer and emits one window per column
// Ports:
//   I_CLK, I_RESET (async, active-low)
//   I_START, I_CENTER_ROW, I_FIRST_LINE, I_LAST_LINE : line request (taken only when idle)
//   O_PIXEL_COL, O_PIXEL_ROW, O_READ_ENABLE, I_PIXEL : frame_buffer read port, data one cycle after strobe
//   O_WINDOW, O_WINDOW_COL, O_VALID, I_READY         : window stream, {TL..BR} with TL in MSBs
//   O_BUSY, O_DONE                                   : line status
module frame_window_reader
  import edge_pkg::*;
#(
  parameter int P_COLUMNS = 640,
  parameter int P_ROWS = 3,
  parameter int P_PIXEL_DEPTH = 24
) (
  input  logic                               I_CLK,
  input  logic                               I_RESET,
  input  logic                               I_START,
  input  logic [$clog2(P_ROWS)-1:0]          I_CENTER_ROW,
  input  logic                               I_FIRST_LINE,
  input  logic                               I_LAST_LINE,
  output logic [$clog2(P_COLUMNS)-1:0]       O_PIXEL_COL,
  output logic [$clog2(P_ROWS)-1:0]          O_PIXEL_ROW,
  output logic                               O_READ_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0]           I_PIXEL,
  output logic [WINDOW_PIXELS*P_PIXEL_DEPTH-1:0] O_WINDOW,
  output logic [$clog2(P_COLUMNS)-1:0]       O_WINDOW_COL,
  output logic                               O_VALID,
  input  logic                               I_READY,
  output logic                               O_BUSY,
  output logic                               O_DONE
);
  localparam int CW = $clog2(P_COLUMNS);
  localparam int RW = $clog2(P_ROWS);
  localparam int D = P_PIXEL_DEPTH;
  if (P_ROWS != 3) begin : g_rows_check
    $error("frame_window_reader supports only P_ROWS = 3");
  end
  state_e state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [CW-1:0] fcol_q, fcol_d, centre_q, centre_d;
  logic [RW-1:0] crow_q, crow_d, top_row, bot_row;
  logic first_q, first_d, last_q, last_d, done_q, done_d;
  logic [D-1:0] top_q, top_d, mid_q, mid_d, vtop, vbot;
  logic [D-1:0] win_q [WINDOW_PIXELS];
  logic [D-1:0] win_d [WINDOW_PIXELS];
  assign top_row = row_wrap(crow_q, 2'd2);
  assign bot_row = row_wrap(crow_q, 2'd1);
  // Border lines still read their replicated row; only the data is substituted here.
  assign vtop = first_q ? mid_q : top_q;
  assign vbot = last_q ? mid_q : I_PIXEL;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    fcol_d = fcol_q;
    centre_d = centre_q;
    crow_d = crow_q;
    first_d = first_q;
    last_d = last_q;
    done_d = 1'b0;
    top_d = top_q;
    mid_d = mid_q;
    win_d = win_q;
    case (state_q)
      IDLE: if (I_START) begin
        state_d = FETCH;
        k_d = 2'd0;
        fcol_d = '0;
        centre_d = '0;
        crow_d = I_CENTER_ROW;
        first_d = I_FIRST_LINE;
        last_d = I_LAST_LINE;
      end
      FETCH: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd1) top_d = I_PIXEL;
        if (k_q == 2'd2) begin
          mid_d = I_PIXEL;
          k_d = 2'd0;
          state_d = LOAD;
        end
      end
      LOAD: if (fcol_q == '0) begin
        // Left border: the missing left column replicates column 0.
        win_d[TL] = vtop;
        win_d[TC] = vtop;
        win_d[ML] = mid_q;
        win_d[MC] = mid_q;
        win_d[BL] = vbot;
        win_d[BC] = vbot;
        fcol_d = CW'(1);
        state_d = FETCH;
      end else begin
        win_d[TR] = vtop;
        win_d[MR] = mid_q;
        win_d[BR] = vbot;
        state_d = EMIT;
      end
      EMIT: if (I_READY) begin
        // Right column stays put, so a window past the right edge replicates it.
        win_d[TL] = win_q[TC];
        win_d[TC] = win_q[TR];
        win_d[ML] = win_q[MC];
        win_d[MC] = win_q[MR];
        win_d[BL] = win_q[BC];
        win_d[BC] = win_q[BR];
        centre_d = centre_q + CW'(1);
        if (centre_q == CW'(P_COLUMNS - 1)) begin
          centre_d = '0;
          done_d = 1'b1;
          state_d = IDLE;
        end else if (int'(centre_q) + 2 <= P_COLUMNS - 1) begin
          fcol_d = centre_q + CW'(2);
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      state_q <= IDLE;
      k_q <= '0;
      fcol_q <= '0;
      centre_q <= '0;
      crow_q <= '0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      top_q <= '0;
      mid_q <= '0;
      win_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      fcol_q <= fcol_d;
      centre_q <= centre_d;
      crow_q <= crow_d;
      first_q <= first_d;
      last_q <= last_d;
      done_q <= done_d;
      top_q <= top_d;
      mid_q <= mid_d;
      win_q <= win_d;
    end
  end
  assign O_READ_ENABLE = state_q == FETCH;
  assign O_PIXEL_COL = O_READ_ENABLE ? fcol_q : '0;
  assign O_PIXEL_ROW = !O_READ_ENABLE ? '0 : (k_q == 2'd0) ? top_row : (k_q == 2'd1) ? crow_q : bot_row;
  assign O_VALID = state_q == EMIT;
  assign O_BUSY = state_q != IDLE;
  assign O_DONE = done_q;
  assign O_WINDOW_COL = centre_q;
  for (genvar i = 0; i < WINDOW_PIXELS; i++) begin : g_pack
    assign O_WINDOW[(WINDOW_PIXELS-1-i)*D +: D] = win_q[i];
  end
endmodule

// File: tb/tb_frame_window_reader.sv
// tb_frame_window_reader: directed checks of the 3x3 window reader at 4 and 640 columns
module tb_frame_window_reader;
  import edge_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, rdy = 1'b1, f = 1'b0, l = 1'b0, sel = 1'b0;
  logic [1:0] cr = '0;
  int pass = 0, total = 0;
  logic re4, val4, busy4, done4, re6, val6, busy6, done6;
  logic [1:0] col4, wcol4, row4, row6;
  logic [9:0] col6, wcol6;
  logic [215:0] win4, win6;
  pixel_t pix4, pix6;
  logic m_re, m_val, m_busy, m_done;
  logic [9:0] m_col, m_wcol;
  logic [215:0] m_win;
  always #5 clk = ~clk;
  frame_window_reader #(.P_COLUMNS(4), .P_ROWS(3), .P_PIXEL_DEPTH(24)) u4 (
    .I_CLK(clk), .I_RESET(rst_n), .I_START(start && !sel), .I_CENTER_ROW(cr), .I_FIRST_LINE(f),
    .I_LAST_LINE(l), .O_PIXEL_COL(col4), .O_PIXEL_ROW(row4), .O_READ_ENABLE(re4), .I_PIXEL(pix4),
    .O_WINDOW(win4), .O_WINDOW_COL(wcol4), .O_VALID(val4), .I_READY(rdy), .O_BUSY(busy4), .O_DONE(done4));
  frame_window_reader #(.P_COLUMNS(640), .P_ROWS(3), .P_PIXEL_DEPTH(24)) u640 (
    .I_CLK(clk), .I_RESET(rst_n), .I_START(start && sel), .I_CENTER_ROW(cr), .I_FIRST_LINE(f),
    .I_LAST_LINE(l), .O_PIXEL_COL(col6), .O_PIXEL_ROW(row6), .O_READ_ENABLE(re6), .I_PIXEL(pix6),
    .O_WINDOW(win6), .O_WINDOW_COL(wcol6), .O_VALID(val6), .I_READY(rdy), .O_BUSY(busy6), .O_DONE(done6));
  function automatic pixel_t pix(input int r, input int c);
    return {r[5:0], c[9:0], 8'hA5};
  endfunction
  always @(posedge clk) begin
    pix4 <= re4 ? pix(int'(row4), int'(col4)) : '0;
    pix6 <= re6 ? pix(int'(row6), int'(col6)) : '0;
  end
  assign m_re = sel ? re6 : re4;
  assign m_val = sel ? val6 : val4;
  assign m_busy = sel ? busy6 : busy4;
  assign m_done = sel ? done6 : done4;
  assign m_col = sel ? col6 : {8'd0, col4};
  assign m_wcol = sel ? wcol6 : {8'd0, wcol4};
  assign m_win = sel ? win6 : win4;
  function automatic logic [215:0] exp_win(input int c, input int ncols, input int crow, input int fi, input int la);
    int rows[3];
    int cols[3];
    logic [215:0] w;
    rows[0] = fi != 0 ? crow : (crow + 2) % 3;
    rows[1] = crow;
    rows[2] = la != 0 ? crow : (crow + 1) % 3;
    cols[0] = c == 0 ? 0 : c - 1;
    cols[1] = c;
    cols[2] = c == ncols - 1 ? c : c + 1;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        w[(8 - (r * 3 + k)) * 24 +: 24] = pix(rows[r], cols[k]);
    return w;
  endfunction
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else pass++;
  endtask
  task automatic run_line(input int ncols, input int c, input int fi, input int la,
                          input int stall_col, input int stall_n, input int busy_start_cyc);
    int cyc, nwin, reads, stall_reads, stalled, first_cyc, last_acc, done_cnt, max_col;
    nwin = 0; reads = 0; stall_reads = 0; stalled = 0; first_cyc = -1; last_acc = -100; done_cnt = 0; max_col = 0;
    @(negedge clk);
    cr = 2'(c); f = fi[0]; l = la[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    for (int t = 0; t < ncols * 6 + 40 && done_cnt == 0; t++) begin
      if (cyc == busy_start_cyc) begin
        start = 1'b1; cr = 2'((c + 1) % 3); f = !fi[0];
      end else if (cyc == busy_start_cyc + 1) begin
        start = 1'b0; cr = 2'(c); f = fi[0];
      end
      if (m_re) begin
        reads++;
        if (int'(m_col) > max_col) max_col = int'(m_col);
        if (stalled > 0 && nwin == stall_col) stall_reads++;
      end
      if (m_done) begin
        done_cnt++;
        chk("done_cycle", 256'(cyc), 256'(last_acc + 1));
      end
      if (m_val) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (int'(m_wcol) == stall_col && stalled < stall_n) begin
          rdy = 1'b0;
          stalled++;
          chk("stall_win", m_win, exp_win(stall_col, ncols, c, fi, la));
        end else begin
          rdy = 1'b1;
          chk("win", m_win, exp_win(nwin, ncols, c, fi, la));
          chk("wcol", m_wcol, 256'(nwin));
          nwin++;
          last_acc = cyc;
        end
      end else rdy = 1'b1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    rdy = 1'b1;
    chk("windows", 256'(nwin), 256'(ncols));
    chk("reads", 256'(reads), 256'(3 * ncols));
    chk("max_col", 256'(max_col), 256'(ncols - 1));
    chk("first_valid_cycle", 256'(first_cyc), 256'(10));
    chk("done_count", 256'(done_cnt), 256'(1));
    if (stall_n > 0) begin
      chk("stall_len", 256'(stalled), 256'(stall_n));
      chk("stall_reads", 256'(stall_reads), 256'(0));
    end
    repeat (3) @(negedge clk);
    chk("idle_after", {m_val, m_busy, m_done}, 256'(0));
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_outs", {val4, busy4, done4, re4}, 256'(0));
    chk("rst_win", win4, 256'(0));
    chk("rst_wcol", wcol4, 256'(0));
    chk("rst_col_row", {col4, row4}, 256'(0));
    chk("rst_outs640", {val6, busy6, done6, re6}, 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; cr = 2'd1; f = 1'b0; l = 1'b0;
    @(negedge clk);
    start = 1'b0; rdy = 1'b0;
    n = 0;
    while (!val4 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_valid", val4, 256'(1));
    #1 rst_n = 1'b0;
    #1 chk("async_rst", {val4, busy4, re4, done4}, 256'(0));
    chk("async_rst_win", win4, 256'(0));
    @(negedge clk);
    rst_n = 1'b1; rdy = 1'b1;
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (done4) n++;
    end
    chk("rst_no_done", 256'(n), 256'(0));
    run_line(4, 1, 0, 0, -1, 0, -1);
    run_line(4, 0, 1, 0, -1, 0, -1);
    run_line(4, 2, 0, 1, -1, 0, -1);
    run_line(4, 1, 0, 0, 1, 7, -1);
    run_line(4, 1, 0, 0, -1, 0, 5);
    sel = 1'b1;
    run_line(640, 2, 0, 0, -1, 0, -1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
